// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the EX stage of the RSA pipeline.
// ADD/SUB/MOV and undefined opcodes finish one cycle after accept.
// MUL (shift-add) and MOD (restoring remainder) retire one bit per cycle
// and finish N+1 cycles after accept.
// Optional macro SEQ_ALU_EXT_FLAGS_EN enables the carry (ALUFlags[2]) and
// overflow (ALUFlags[3]) flags. When it is undefined both bits read 0 and
// their logic is not built.
// Handshake: a request is taken on any rising edge where valid_i && ready_o.
// ready_o is high in IDLE and DONE. valid_o pulses for the single DONE cycle.
// state_q (state_e) is the FSM state that checkers should bind to.
module seq_alu #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   opcode_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [N-1:0] result_o,
  output logic [3:0]   ALUFlags
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_MUL = 2'd1,
    S_BUSY_MOD = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  // hi_q: MUL upper product / MOD partial remainder
  // lo_q: MUL multiplier then low product / MOD dividend shifting out
  // op_q: MUL multiplicand / MOD divisor
  logic [N-1:0]  hi_q, lo_q, op_q;
  logic [N-1:0]  result_q;
  logic [1:0]    zn_q;

  logic          accept, busy, last_iter, load_res;
  logic [N-1:0]  mul_addend, mod_rem, fin_res;
  logic [N:0]    mul_sum, mod_sh, mod_diff;

`ifdef SEQ_ALU_EXT_FLAGS_EN
  logic [1:0]    cv_q;
  logic          fin_c, fin_v;
  logic [N:0]    add_w, sub_w;
`endif

  assign accept    = valid_i && ready_o;
  assign busy      = (state_q == S_BUSY_MUL) || (state_q == S_BUSY_MOD);
  assign last_iter = (cnt_q == CW'(N - 1));
  // Result registers load on a single-cycle accept or on the last iteration.
  assign load_res  = (accept && (state_d == S_DONE)) || (busy && last_iter);

  // State register
  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          case (opcode_i)
            3'b010:  state_d = S_BUSY_MUL;
            3'b100:  state_d = (b_i != '0) ? S_BUSY_MOD : S_DONE;
            default: state_d = S_DONE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY_MUL, S_BUSY_MOD: begin
        if (last_iter) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin : output_comb
    ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
    valid_o = (state_q == S_DONE);
  end

  // One iteration step of the shift-add multiplier and restoring remainder
  always_comb begin : step_comb
    mul_addend = lo_q[0] ? op_q : '0;
    mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    mod_sh     = {hi_q, lo_q[N-1]};
    mod_diff   = mod_sh - {1'b0, op_q};
    // A borrow means the shifted remainder is still below the divisor.
    mod_rem    = mod_diff[N] ? mod_sh[N-1:0] : mod_diff[N-1:0];
  end

  // Value and flags to be registered when an operation completes
  always_comb begin : finish_comb
    fin_res = '0;
`ifdef SEQ_ALU_EXT_FLAGS_EN
    fin_c = 1'b0;
    fin_v = 1'b0;
    add_w = {1'b0, a_i} + {1'b0, b_i};
    sub_w = {1'b0, a_i} - {1'b0, b_i};
`endif
    if (state_q == S_BUSY_MUL) begin
      fin_res = {mul_sum[0], lo_q[N-1:1]};
`ifdef SEQ_ALU_EXT_FLAGS_EN
      fin_c = |mul_sum[N:1];
`endif
    end else if (state_q == S_BUSY_MOD) begin
      fin_res = mod_rem;
    end else begin
      case (opcode_i)
        3'b000: begin
`ifdef SEQ_ALU_EXT_FLAGS_EN
          fin_res = add_w[N-1:0];
          fin_c   = add_w[N];
          fin_v   = (a_i[N-1] == b_i[N-1]) && (add_w[N-1] != a_i[N-1]);
`else
          fin_res = a_i + b_i;
`endif
        end
        3'b001: begin
`ifdef SEQ_ALU_EXT_FLAGS_EN
          fin_res = sub_w[N-1:0];
          fin_c   = ~sub_w[N];
          fin_v   = (a_i[N-1] != b_i[N-1]) && (sub_w[N-1] != a_i[N-1]);
`else
          fin_res = a_i - b_i;
`endif
        end
        3'b011: fin_res = b_i;
        // Only loaded for a zero divisor; non-zero divisors go iterative.
        3'b100: begin
          fin_res = a_i;
`ifdef SEQ_ALU_EXT_FLAGS_EN
          fin_v = 1'b1;
`endif
        end
        default: fin_res = '0;
      endcase
    end
  end

  // Iteration registers: load operands on accept, step while busy
  always_ff @(posedge clk_i) begin : iter_reg
    if (rst_i) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      hi_q  <= '0;
      if (opcode_i == 3'b010) begin
        lo_q <= b_i;
        op_q <= a_i;
      end else begin
        lo_q <= a_i;
        op_q <= b_i;
      end
    end else if (state_q == S_BUSY_MUL) begin
      hi_q  <= mul_sum[N:1];
      lo_q  <= {mul_sum[0], lo_q[N-1:1]};
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == S_BUSY_MOD) begin
      hi_q  <= mod_rem;
      lo_q  <= {lo_q[N-2:0], 1'b0};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result and flag registers, held between completions
  always_ff @(posedge clk_i) begin : result_reg
    if (rst_i) begin
      result_q <= '0;
      zn_q     <= '0;
`ifdef SEQ_ALU_EXT_FLAGS_EN
      cv_q     <= '0;
`endif
    end else if (load_res) begin
      result_q <= fin_res;
      zn_q     <= {fin_res[N-1], fin_res == '0};
`ifdef SEQ_ALU_EXT_FLAGS_EN
      cv_q     <= {fin_v, fin_c};
`endif
    end
  end

  assign result_o = result_q;
`ifdef SEQ_ALU_EXT_FLAGS_EN
  assign ALUFlags = {cv_q, zn_q};
`else
  assign ALUFlags = {2'b00, zn_q};
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu at N=8: directed vector table, hand-written
// multi-cycle sequences (back-to-back, reset mid-operation, reset with
// valid), then random operations against a behavioural model.
module tb_seq_alu;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i, valid_i;
  logic [N-1:0] a_i, b_i;
  logic [2:0]   opcode_i;
  logic         ready_o, valid_o;
  logic [N-1:0] result_o;
  logic [3:0]   ALUFlags;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_alu #(.N(N)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .opcode_i (opcode_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .ALUFlags (ALUFlags)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      nm;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;  // {V,C,N,Z} as with the extended flags enabled
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Flags as seen on ALUFlags for the current build.
  function automatic logic [3:0] fmask(input logic [3:0] f);
`ifdef SEQ_ALU_EXT_FLAGS_EN
    return f;
`else
    return {2'b00, f[1:0]};
`endif
  endfunction

  // Behavioural reference: plain integer arithmetic on the operation rules.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic [3:0] f, output int lat);
    int ua, ub, sa, sb, full, sfull;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0;
    v = 1'b0;
    lat = 1;
    full = 0;
    case (op)
      3'd0: begin
        full = ua + ub;
        sfull = sa + sb;
        c = (full > 255);
        v = (sfull > 127) || (sfull < -128);
      end
      3'd1: begin
        full = ua - ub + 256;
        sfull = sa - sb;
        c = (ua >= ub);
        v = (sfull > 127) || (sfull < -128);
      end
      3'd2: begin
        full = ua * ub;
        c = (full > 255);
        lat = N + 1;
      end
      3'd3: full = ub;
      3'd4: begin
        if (ub == 0) begin
          full = ua;
          v = 1'b1;
        end else begin
          full = ua % ub;
          lat = N + 1;
        end
      end
      default: full = 0;
    endcase
    r = 8'(full % 256);
    f = fmask({v, c, r[7], r == 8'h00});
  endfunction

  // Drive one request, wait (bounded) for valid_o, check latency/result/flags.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                        input int elat);
    int waitc, k, busy_low;
    waitc = 0;
    @(negedge clk_i);
    while (!ready_o && waitc < 30) begin
      @(negedge clk_i);
      waitc++;
    end
    if (waitc >= 30) check({nm, ".ready_timeout"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    opcode_i = op;
    a_i = a;
    b_i = b;
    @(negedge clk_i);
    k = 1;
    busy_low = 0;
    while (!valid_o && k < 30) begin
      if (!ready_o) busy_low++;
      // Requests offered while busy must be ignored.
      valid_i = 1'($urandom_range(0, 1));
      opcode_i = 3'($urandom_range(0, 7));
      a_i = 8'($urandom);
      b_i = 8'($urandom);
      @(negedge clk_i);
      k++;
    end
    valid_i = 1'b0;
    check({nm, ".latency"}, 32'(k), 32'(elat));
    check({nm, ".busy_cycles"}, 32'(busy_low), 32'(elat - 1));
    check({nm, ".result"}, 32'(result_o), 32'(er));
    check({nm, ".flags"}, 32'(ALUFlags), 32'(ef));
    @(negedge clk_i);
    check({nm, ".pulse_end"}, 32'(valid_o), 32'd0);
    check({nm, ".held"}, {20'd0, ALUFlags, result_o}, {20'd0, ef, er});
  endtask

  initial begin
    logic [7:0] r;
    logic [3:0] f;
    logic [2:0] op;
    logic [7:0] a, b;
    int lat, seen;

    vecs[0]  = '{"add_7f_01",  3'd0, 8'h7F, 8'h01, 8'h80, 4'hA, 1};
    vecs[1]  = '{"sub_05_05",  3'd1, 8'h05, 8'h05, 8'h00, 4'h5, 1};
    vecs[2]  = '{"mul_10_10",  3'd2, 8'h10, 8'h10, 8'h00, 4'h5, 9};
    vecs[3]  = '{"mul_0c_0b",  3'd2, 8'h0C, 8'h0B, 8'h84, 4'h2, 9};
    vecs[4]  = '{"mod_c8_07",  3'd4, 8'hC8, 8'h07, 8'h04, 4'h0, 9};
    vecs[5]  = '{"mod_2a_00",  3'd4, 8'h2A, 8'h00, 8'h2A, 4'h8, 1};
    vecs[6]  = '{"add_ff_01",  3'd0, 8'hFF, 8'h01, 8'h00, 4'h5, 1};
    vecs[7]  = '{"sub_00_01",  3'd1, 8'h00, 8'h01, 8'hFF, 4'h2, 1};
    vecs[8]  = '{"sub_80_01",  3'd1, 8'h80, 8'h01, 8'h7F, 4'hC, 1};
    vecs[9]  = '{"mov_90",     3'd3, 8'h11, 8'h90, 8'h90, 4'h2, 1};
    vecs[10] = '{"undef_5",    3'd5, 8'h03, 8'h04, 8'h00, 4'h1, 1};
    vecs[11] = '{"mod_ff_10",  3'd4, 8'hFF, 8'h10, 8'h0F, 4'h0, 9};

    // Reset
    rst_i = 1'b1;
    valid_i = 1'b0;
    opcode_i = 3'd0;
    a_i = '0;
    b_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("reset.ready", 32'(ready_o), 32'd1);
    check("reset.valid", 32'(valid_o), 32'd0);
    check("reset.result", 32'(result_o), 32'd0);
    check("reset.flags", 32'(ALUFlags), 32'd0);

    // Directed vector table
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             fmask(vecs[i].flg), vecs[i].lat);

    // Back-to-back: ADD accepted in the DONE cycle of a SUB
    @(negedge clk_i);
    valid_i = 1'b1; opcode_i = 3'd1; a_i = 8'h05; b_i = 8'h05;
    @(negedge clk_i);
    check("b2b.valid1", 32'(valid_o), 32'd1);
    check("b2b.ready1", 32'(ready_o), 32'd1);
    check("b2b.result1", 32'(result_o), 32'h00);
    check("b2b.flags1", 32'(ALUFlags), 32'(fmask(4'h5)));
    opcode_i = 3'd0; a_i = 8'h01; b_i = 8'h02;
    @(negedge clk_i);
    valid_i = 1'b0;
    check("b2b.valid2", 32'(valid_o), 32'd1);
    check("b2b.result2", 32'(result_o), 32'h03);
    check("b2b.flags2", 32'(ALUFlags), 32'd0);
    @(negedge clk_i);
    check("b2b.valid3", 32'(valid_o), 32'd0);

    // Reset three cycles into a MUL: the op is abandoned
    valid_i = 1'b1; opcode_i = 3'd2; a_i = 8'h0C; b_i = 8'h0B;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rstmul.valid", 32'(valid_o), 32'd0);
    check("rstmul.result", 32'(result_o), 32'd0);
    check("rstmul.flags", 32'(ALUFlags), 32'd0);
    check("rstmul.ready", 32'(ready_o), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check("rstmul.no_valid", 32'(seen), 32'd0);
    run_op("rstmul.add", 3'd0, 8'h01, 8'h01, 8'h02, 4'h0, 1);

    // Reset and valid in the same cycle: nothing accepted
    rst_i = 1'b1; valid_i = 1'b1; opcode_i = 3'd0; a_i = 8'h03; b_i = 8'h04;
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0;
    check("rstvalid.valid", 32'(valid_o), 32'd0);
    check("rstvalid.result", 32'(result_o), 32'd0);
    @(negedge clk_i);
    check("rstvalid.valid_late", 32'(valid_o), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      model(op, a, b, r, f, lat);
      run_op("rnd", op, a, b, r, f, lat);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
